// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: response codes and initiator FSM states shared by the AXI4-Lite master.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESPOND
    } axi4_lite_master_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite initiator bridging a cmd/rsp stream onto AW/W/B and AR/R.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_SIZE  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_clk_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]  cmd_address_i,
    input  logic [DATA_SIZE-1:0]   cmd_data_i,
    input  logic [DATA_SIZE/8-1:0] cmd_strb_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_write_o,
    output logic [DATA_SIZE-1:0]   rsp_data_o,
    output logic [1:0]             rsp_resp_o,
    output logic [ADDR_WIDTH-1:0]  write_address_o,
    output logic                   write_address_valid_o,
    input  logic                   write_address_ready_i,
    output logic [DATA_SIZE-1:0]   write_data_o,
    output logic [DATA_SIZE/8-1:0] write_data_strb_o,
    output logic                   write_data_valid_o,
    input  logic                   write_data_ready_i,
    input  logic [1:0]             write_response_i,
    input  logic                   write_response_valid_i,
    output logic                   write_response_ready_o,
    output logic [ADDR_WIDTH-1:0]  read_address_o,
    output logic                   read_address_valid_o,
    input  logic                   read_address_ready_i,
    input  logic [DATA_SIZE-1:0]   read_data_i,
    input  logic [1:0]             read_data_response_i,
    input  logic                   read_data_valid_i,
    output logic                   read_data_ready_o
);

    axi4_lite_master_state_t state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_SIZE-1:0]   data_q, data_d;
    logic [DATA_SIZE/8-1:0] strb_q, strb_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [DATA_SIZE-1:0]   rsp_data_q, rsp_data_d;
    axi_resp_t              rsp_resp_q, rsp_resp_d;

    // Every handshake output is a pure decode of registered state, never of an incoming ready.
    assign cmd_ready_o            = cmd_ready_q;
    assign write_address_o        = addr_q;
    assign write_address_valid_o  = (state_q == WR_ADDR_DATA) && !aw_done_q;
    assign write_data_o           = data_q;
    assign write_data_strb_o      = strb_q;
    assign write_data_valid_o     = (state_q == WR_ADDR_DATA) && !w_done_q;
    assign write_response_ready_o = state_q == WR_RESP;
    assign read_address_o         = addr_q;
    assign read_address_valid_o   = state_q == RD_ADDR;
    assign read_data_ready_o      = state_q == RD_DATA;
    assign rsp_valid_o            = state_q == RESPOND;
    assign rsp_write_o            = write_q;
    assign rsp_data_o             = rsp_data_q;
    assign rsp_resp_o             = rsp_resp_q;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        case (state_q)
            IDLE: if (cmd_valid_i && cmd_ready_q) begin
                write_d   = cmd_write_i;
                addr_d    = cmd_address_i;
                data_d    = cmd_data_i;
                strb_d    = cmd_strb_i;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = cmd_write_i ? WR_ADDR_DATA : RD_ADDR;
            end
            WR_ADDR_DATA: begin
                aw_done_d = aw_done_q || (write_address_valid_o && write_address_ready_i);
                w_done_d  = w_done_q || (write_data_valid_o && write_data_ready_i);
                state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_ADDR_DATA;
            end
            WR_RESP: if (write_response_valid_i) begin
                rsp_data_d = '0;
                rsp_resp_d = axi_resp_t'(write_response_i);
                state_d    = RESPOND;
            end
            RD_ADDR: state_d = read_address_ready_i ? RD_DATA : RD_ADDR;
            RD_DATA: if (read_data_valid_i) begin
                rsp_data_d = read_data_i;
                rsp_resp_d = axi_resp_t'(read_data_response_i);
                state_d    = RESPOND;
            end
            RESPOND: state_d = rsp_ready_i ? IDLE : RESPOND;
            default: state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_clk_i) begin
        if (rst_clk_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed commands against a delay-configurable slave model; responses scored from a queue.
module tb_axi4_lite_master;

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } rsp_t;

    typedef struct {
        string       n;
        logic [63:0] a;
        logic [63:0] e;
    } chk_t;

    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0, cmd_data = 0;
    logic [3:0] cmd_strb = 0;
    logic rsp_valid, rsp_ready = 1, rsp_write;
    logic [31:0] rsp_data;
    logic [1:0] rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0] wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;

    int total = 0, bad = 0;
    rsp_t exp_q[$];
    chk_t chk_q[$];

    axi4_lite_master dut (
        .clk_i(clk), .rst_clk_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_address_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
        .rsp_data_o(rsp_data), .rsp_resp_o(rsp_resp),
        .write_address_o(awaddr), .write_address_valid_o(awvalid), .write_address_ready_i(awready),
        .write_data_o(wdata), .write_data_strb_o(wstrb), .write_data_valid_o(wvalid),
        .write_data_ready_i(wready),
        .write_response_i(bresp), .write_response_valid_i(bvalid), .write_response_ready_o(bready),
        .read_address_o(araddr), .read_address_valid_o(arvalid), .read_address_ready_i(arready),
        .read_data_i(rdata), .read_data_response_i(rresp), .read_data_valid_i(rvalid),
        .read_data_ready_o(rready)
    );

    always #5 clk = ~clk;

    // Slave model: AW/W ready after a programmable number of waiting cycles, B/R one cycle after.
    int aw_delay = 0, w_delay = 0, aw_cnt, w_cnt;
    logic [1:0] bresp_cfg = 0, rresp_cfg = 0;
    logic [31:0] mem [64];
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0] w_s;
    logic aw_got, w_got, a_ok, d_ok;
    logic [31:0] a_now, d_now;
    logic [3:0] s_now;

    assign awready = aw_cnt >= aw_delay;
    assign wready  = w_cnt >= w_delay;
    assign arready = 1'b1;
    assign a_ok  = aw_got || (awvalid && awready);
    assign d_ok  = w_got || (wvalid && wready);
    assign a_now = aw_got ? aw_a : awaddr;
    assign d_now = w_got ? w_d : wdata;
    assign s_now = w_got ? w_s : wstrb;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = s[i] ? d[i*8 +: 8] : old[i*8 +: 8];
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 0; w_got <= 0;
            bvalid <= 0; rvalid <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
            aw_a <= 0; w_d <= 0; w_s <= 0; ar_a <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= 0;
            mem[63] <= 32'hCAFEF00D;
        end else begin
            if (awvalid) aw_cnt <= awready ? 0 : aw_cnt + 1;
            if (wvalid) w_cnt <= wready ? 0 : w_cnt + 1;
            if (awvalid && awready) begin aw_got <= 1; aw_a <= awaddr; end
            if (wvalid && wready) begin w_got <= 1; w_d <= wdata; w_s <= wstrb; end
            if (a_ok && d_ok && !bvalid) begin
                bvalid <= 1; bresp <= bresp_cfg;
                mem[a_now[7:2]] <= merge(mem[a_now[7:2]], d_now, s_now);
                aw_got <= 0; w_got <= 0;
            end
            if (bvalid && bready) bvalid <= 0;
            if (arvalid && arready && !rvalid) begin
                rvalid <= 1; rdata <= mem[araddr[7:2]]; rresp <= rresp_cfg; ar_a <= araddr;
            end
            if (rvalid && rready) rvalid <= 0;
        end
    end

    // Event timestamps relative to a free-running cycle counter.
    int cyc = 0, acc_cyc, aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, rv_cyc, rsp_hs_cyc;
    int aw_hi, w_hi, b_cnt;
    logic rv_prev = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rv_prev <= rsp_valid;
        if (rsp_valid && !rv_prev) rv_cyc <= cyc;
        if (rsp_valid && rsp_ready) rsp_hs_cyc <= cyc;
        if (cmd_valid && cmd_ready) begin
            acc_cyc <= cyc; aw_hi <= 0; w_hi <= 0; b_cnt <= 0;
        end else begin
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid) w_hi <= w_hi + 1;
            if (bvalid && bready) b_cnt <= b_cnt + 1;
        end
        if (awvalid && awready) aw_cyc <= cyc;
        if (wvalid && wready) w_cyc <= cyc;
        if (bvalid && bready) b_cyc <= cyc;
        if (arvalid && arready) ar_cyc <= cyc;
        if (rvalid && rready) r_cyc <= cyc;
    end

    task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Checker: drains directed checks, and scores each response handshake against the expectation queue.
    always @(negedge clk) begin
        chk_t c;
        rsp_t e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.n, c.a, c.e);
        end
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) cmp("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                cmp("rsp_write", 64'(rsp_write), 64'(e.w));
                cmp("rsp_data", 64'(rsp_data), 64'(e.d));
                cmp("rsp_resp", 64'(rsp_resp), 64'(e.r));
            end
        end
    end

    function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
        chk_q.push_back('{n, a, e});
    endfunction

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] ed, input logic [1:0] er);
        logic ok = 0;
        exp_q.push_back('{w, w ? 32'd0 : ed, er});
        cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        logic ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        chk("rsp_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic ok;
        logic [35:0] snap;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
        chk("rst_rsp", 64'({rsp_write, rsp_resp, rsp_data}), 64'd0);
        chk("rst_addr", {awaddr, araddr}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // 1: zero-wait write
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 2'b00);
        wait_done();
        chk("t1_aw_lat", 64'(aw_cyc - acc_cyc), 64'd1);
        chk("t1_w_lat", 64'(w_cyc - acc_cyc), 64'd1);
        chk("t1_b_lat", 64'(b_cyc - acc_cyc), 64'd2);
        chk("t1_rv_lat", 64'(rv_cyc - acc_cyc), 64'd3);

        // 2: read back
        issue(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
        wait_done();
        chk("t2_araddr", 64'(ar_a), 64'h10);
        chk("t2_ar_lat", 64'(ar_cyc - acc_cyc), 64'd1);
        chk("t2_r_lat", 64'(r_cyc - acc_cyc), 64'd2);
        chk("t2_rv_lat", 64'(rv_cyc - acc_cyc), 64'd3);

        // 3: AWREADY three cycles late, partial strobe
        aw_delay = 3;
        issue(1, 32'h20, 32'h12345678, 4'h3, 0, 2'b00);
        wait_done();
        chk("t3_aw_cycles", 64'(aw_hi), 64'd4);
        chk("t3_w_cycles", 64'(w_hi), 64'd1);
        chk("t3_b_count", 64'(b_cnt), 64'd1);
        aw_delay = 0;
        issue(0, 32'h20, 32'h0, 4'h0, 32'h00005678, 2'b00);
        wait_done();

        // 4: SLVERR read, data passed through
        rresp_cfg = 2'b10;
        issue(0, 32'hFC, 32'h0, 4'h0, 32'hCAFEF00D, 2'b10);
        wait_done();
        rresp_cfg = 2'b00;

        // 5: response back-pressure, DECERR write
        bresp_cfg = 2'b11;
        rsp_ready = 0;
        issue(1, 32'h30, 32'hA5A5A5A5, 4'hF, 0, 2'b11);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        chk("t5_rsp_valid_timeout", 64'(ok), 64'd1);
        snap = {rsp_valid, rsp_write, rsp_resp, rsp_data};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_rsp_stable", 64'({rsp_valid, rsp_write, rsp_resp, rsp_data}), 64'(snap));
            chk("t5_cmd_ready_low", 64'(cmd_ready), 64'd0);
        end
        bresp_cfg = 2'b00;
        @(posedge clk); #1;
        rsp_ready = 1;
        issue(0, 32'h30, 32'h0, 4'h0, 32'hA5A5A5A5, 2'b00);
        chk("t5_next_accept", 64'(acc_cyc - rsp_hs_cyc), 64'd1);
        wait_done();

        // 6: asynchronous reset while AW is stalled
        aw_delay = 20;
        issue(1, 32'h40, 32'h11111111, 4'hF, 0, 2'b00);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("t6_valids_drop", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        aw_delay = 0;
        issue(1, 32'h40, 32'h11111111, 4'hF, 0, 2'b00);
        wait_done();
        chk("t6_rv_lat", 64'(rv_cyc - acc_cyc), 64'd3);
        issue(0, 32'h40, 32'h0, 4'h0, 32'h11111111, 2'b00);
        wait_done();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
